// File: rtl/reg_writeback_if.sv
// Bundle of the two write-request ports, the mode/hold controls and the
// physical register-file write port of reg_writeback.
interface reg_writeback_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [4:0]    mode;
    logic          a_valid;
    logic          a_ready;
    logic [3:0]    a_addr;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [3:0]    b_addr;
    logic [DW-1:0] b_data;
    logic          hold;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [30:0]   pending;
    logic          err_mode;
    logic [CW-1:0] fifo_count;

    // Handshake: a request transfers on a rising edge where x_valid and x_ready
    // are both high; x_ready never depends on the cycle's pop.
    modport master (
        output mode, a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold,
        input  a_ready, b_ready, wr_en, wr_addr, wr_data, pending, err_mode,
               fifo_count
    );

    modport slave (
        input  mode, a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold,
        output a_ready, b_ready, wr_en, wr_addr, wr_data, pending, err_mode,
               fifo_count
    );
endinterface

// File: rtl/reg_writeback.sv
// Register write-back queue: round-robin merge of ALU and load-unit writes,
// banked-register mapping at accept time, in-order drain to the register file.
// Optional feature macro: WB_BYPASS_EN (same-cycle write when queue is empty).
module reg_writeback #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input logic           clk,
    input logic           rst_n,
    reg_writeback_if.slave wb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [4:0] M_USR = 5'b10000;
    localparam logic [4:0] M_FIQ = 5'b10001;
    localparam logic [4:0] M_IRQ = 5'b10010;
    localparam logic [4:0] M_SVC = 5'b10011;
    localparam logic [4:0] M_ABT = 5'b10111;
    localparam logic [4:0] M_UND = 5'b11011;
    localparam logic [4:0] M_SYS = 5'b11111;

    function automatic logic mode_ok(input logic [4:0] m);
        logic ok;
        case (m)
            M_USR, M_SYS, M_FIQ, M_IRQ, M_SVC, M_ABT, M_UND: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [4:0] map_addr(input logic [4:0] m, input logic [3:0] r);
        logic [4:0] p;
        logic       r13;
        logic       r14;
        p   = {1'b0, r};
        r13 = (r == 4'd13);
        r14 = (r == 4'd14);
        case (m)
            M_FIQ: if (r >= 4'd8 && r <= 4'd14) p = {1'b0, r} + 5'd8;
            M_IRQ: if (r13) p = 5'd23; else if (r14) p = 5'd24;
            M_SVC: if (r13) p = 5'd25; else if (r14) p = 5'd26;
            M_ABT: if (r13) p = 5'd27; else if (r14) p = 5'd28;
            M_UND: if (r13) p = 5'd29; else if (r14) p = 5'd30;
            default: p = {1'b0, r};
        endcase
        return p;
    endfunction

    logic [4:0]    addr_mem_q [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          rr_q, rr_d;
    logic          err_q, err_d;

    logic          full, empty;
    logic          grant_a, grant_b;
    logic          acc, sel_ok, bypass, push, pop;
    logic [3:0]    sel_raddr;
    logic [4:0]    sel_paddr;
    logic [DW-1:0] sel_data;
    logic [30:0]   pending_c;

    // Arbitration: rr_q = 0 favours port A, 1 favours port B.
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        grant_a = wb.a_valid && (!wb.b_valid || !rr_q);
        grant_b = wb.b_valid && !grant_a;
    end

    assign wb.a_ready = rst_n && grant_a && !full;
    assign wb.b_ready = rst_n && grant_b && !full;

    always_comb begin
        acc       = wb.a_ready || wb.b_ready;
        sel_ok    = mode_ok(wb.mode);
        sel_raddr = wb.b_ready ? wb.b_addr : wb.a_addr;
        sel_data  = wb.b_ready ? wb.b_data : wb.a_data;
        sel_paddr = map_addr(wb.mode, sel_raddr);
    end

`ifdef WB_BYPASS_EN
    assign bypass = empty && !wb.hold && acc && sel_ok;
`else
    assign bypass = 1'b0;
`endif

    assign push = acc && sel_ok && !bypass;
    assign pop  = !empty && !wb.hold;

    always_comb begin
        wp_d    = push ? wp_q + AW'(1) : wp_q;
        rp_d    = pop  ? rp_q + AW'(1) : rp_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        rr_d  = acc ? wb.a_ready : rr_q;
        err_d = acc && !sel_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            // Push and pop never share a slot: push needs not-full, pop needs not-empty.
            if (pop) vld_q[rp_q] <= 1'b0;
            if (push) begin
                vld_q[wp_q]      <= 1'b1;
                addr_mem_q[wp_q] <= sel_paddr;
                data_mem_q[wp_q] <= sel_data;
            end
        end
    end

    always_comb begin
        pending_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int p = 0; p < 31; p++) begin
                if (vld_q[i] && (addr_mem_q[i] == 5'(p))) pending_c[p] = 1'b1;
            end
        end
    end

    assign wb.wr_en      = pop || bypass;
    assign wb.wr_addr    = bypass ? sel_paddr : addr_mem_q[rp_q];
    assign wb.wr_data    = bypass ? sel_data  : data_mem_q[rp_q];
    assign wb.pending    = pending_c;
    assign wb.err_mode   = err_q;
    assign wb.fifo_count = count_q;
endmodule
